// File: rtl/trdb_filter_regs.sv
// APB register block for the trace filter: software programs shadow registers,
// then a CTRL write with bit31 set copies them atomically into the active set.
module trdb_filter_regs #(
  parameter int XLEN      = 32,
  parameter int CAUSE_LEN = 5,
  parameter int PRIV_LEN  = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [7:0]           paddr_i,
  input  logic                 psel_i,
  input  logic                 penable_i,
  input  logic                 pwrite_i,
  input  logic [31:0]          pwdata_i,
  output logic [31:0]          prdata_o,
  output logic                 pready_o,
  output logic                 pslverr_o,
  output logic                 trace_enable_o,
  output logic                 cause_filter_o,
  output logic                 tvec_filter_o,
  output logic                 tval_filter_o,
  output logic                 priv_lvl_filter_o,
  output logic                 iaddr_filter_o,
  output logic                 cause_mode_o,
  output logic                 tvec_mode_o,
  output logic                 tval_mode_o,
  output logic                 priv_lvl_mode_o,
  output logic                 iaddr_mode_o,
  output logic [CAUSE_LEN-1:0] upper_cause_o,
  output logic [CAUSE_LEN-1:0] lower_cause_o,
  output logic [CAUSE_LEN-1:0] match_cause_o,
  output logic [XLEN-3:0]      upper_tvec_o,
  output logic [XLEN-3:0]      lower_tvec_o,
  output logic [XLEN-3:0]      match_tvec_o,
  output logic [XLEN-1:0]      upper_tval_o,
  output logic [XLEN-1:0]      lower_tval_o,
  output logic [XLEN-1:0]      match_tval_o,
  output logic [PRIV_LEN-1:0]  upper_priv_lvl_o,
  output logic [PRIV_LEN-1:0]  lower_priv_lvl_o,
  output logic [PRIV_LEN-1:0]  match_priv_lvl_o,
  output logic [XLEN-1:0]      upper_iaddr_o,
  output logic [XLEN-1:0]      lower_iaddr_o,
  output logic [XLEN-1:0]      match_iaddr_o,
  output logic                 commit_o
);

  // Index 0 = upper, 1 = lower, 2 = match for every bounded field.
  typedef struct packed {
    logic [10:0]                 ctrl;
    logic [2:0][CAUSE_LEN-1:0]   cause;
    logic [2:0][XLEN-3:0]        tvec;
    logic [2:0][XLEN-1:0]        tval;
    logic [2:0][PRIV_LEN-1:0]    priv;
    logic [2:0][XLEN-1:0]        iaddr;
  } cfg_t;

  typedef enum logic [0:0] {IDLE = 1'b0, COMMIT = 1'b1} state_t;

  cfg_t       shadow_r, shadow_nxt_s, active_r;
  state_t     state_r, state_nxt_s;
  logic       pending_r, commit_r, load_s;
  logic [5:0] word_s;
  logic       access_s, err_s, wr_s, commit_req_s;
  logic [1:0] unused_addr_s;
  logic [31:0] rdata_s;

  assign unused_addr_s = paddr_i[1:0];
  assign word_s        = paddr_i[7:2];
  assign access_s      = psel_i & penable_i;
  assign err_s         = access_s & ((word_s > 6'd16) | (pwrite_i & (word_s == 6'd16)));
  assign wr_s          = access_s & pwrite_i & ~err_s;
  assign commit_req_s  = wr_s & (word_s == 6'd0) & pwdata_i[31];

  // Shadow write decode
  always_comb begin
    shadow_nxt_s = shadow_r;
    if (wr_s) begin
      case (word_s)
        6'd0:    shadow_nxt_s.ctrl     = pwdata_i[10:0];
        6'd1:    shadow_nxt_s.cause[0] = pwdata_i[CAUSE_LEN-1:0];
        6'd2:    shadow_nxt_s.cause[1] = pwdata_i[CAUSE_LEN-1:0];
        6'd3:    shadow_nxt_s.cause[2] = pwdata_i[CAUSE_LEN-1:0];
        6'd4:    shadow_nxt_s.tvec[0]  = pwdata_i[XLEN-1:2];
        6'd5:    shadow_nxt_s.tvec[1]  = pwdata_i[XLEN-1:2];
        6'd6:    shadow_nxt_s.tvec[2]  = pwdata_i[XLEN-1:2];
        6'd7:    shadow_nxt_s.tval[0]  = pwdata_i;
        6'd8:    shadow_nxt_s.tval[1]  = pwdata_i;
        6'd9:    shadow_nxt_s.tval[2]  = pwdata_i;
        6'd10:   shadow_nxt_s.priv[0]  = pwdata_i[PRIV_LEN-1:0];
        6'd11:   shadow_nxt_s.priv[1]  = pwdata_i[PRIV_LEN-1:0];
        6'd12:   shadow_nxt_s.priv[2]  = pwdata_i[PRIV_LEN-1:0];
        6'd13:   shadow_nxt_s.iaddr[0] = pwdata_i;
        6'd14:   shadow_nxt_s.iaddr[1] = pwdata_i;
        6'd15:   shadow_nxt_s.iaddr[2] = pwdata_i;
        default: shadow_nxt_s = shadow_r;
      endcase
    end else begin
      shadow_nxt_s = shadow_r;
    end
  end

  // Read mux: shadow values, zero outside a read access phase
  always_comb begin
    rdata_s = 32'd0;
    if (access_s & ~pwrite_i) begin
      case (word_s)
        6'd0:    rdata_s = {21'd0, shadow_r.ctrl};
        6'd1:    rdata_s = {{(32-CAUSE_LEN){1'b0}}, shadow_r.cause[0]};
        6'd2:    rdata_s = {{(32-CAUSE_LEN){1'b0}}, shadow_r.cause[1]};
        6'd3:    rdata_s = {{(32-CAUSE_LEN){1'b0}}, shadow_r.cause[2]};
        6'd4:    rdata_s = {shadow_r.tvec[0], 2'b00};
        6'd5:    rdata_s = {shadow_r.tvec[1], 2'b00};
        6'd6:    rdata_s = {shadow_r.tvec[2], 2'b00};
        6'd7:    rdata_s = shadow_r.tval[0];
        6'd8:    rdata_s = shadow_r.tval[1];
        6'd9:    rdata_s = shadow_r.tval[2];
        6'd10:   rdata_s = {{(32-PRIV_LEN){1'b0}}, shadow_r.priv[0]};
        6'd11:   rdata_s = {{(32-PRIV_LEN){1'b0}}, shadow_r.priv[1]};
        6'd12:   rdata_s = {{(32-PRIV_LEN){1'b0}}, shadow_r.priv[2]};
        6'd13:   rdata_s = shadow_r.iaddr[0];
        6'd14:   rdata_s = shadow_r.iaddr[1];
        6'd15:   rdata_s = shadow_r.iaddr[2];
        6'd16:   rdata_s = {31'd0, pending_r};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // Commit FSM next state; load_s marks the cycle whose closing edge copies shadow
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (commit_req_s) state_nxt_s = COMMIT;
        else              state_nxt_s = IDLE;
      end
      COMMIT: begin
        load_s      = 1'b1;
        state_nxt_s = IDLE;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State, shadow/active registers, pending flag and commit pulse
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r   <= IDLE;
      shadow_r  <= '0;
      active_r  <= '0;
      pending_r <= 1'b0;
      commit_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      shadow_r <= shadow_nxt_s;
      commit_r <= load_s;
      if (load_s) active_r <= shadow_r;
      // Clear on commit takes priority over a coincident shadow write.
      if (load_s)    pending_r <= 1'b0;
      else if (wr_s) pending_r <= 1'b1;
    end
  end

  assign prdata_o          = rdata_s;
  assign pready_o          = 1'b1;
  assign pslverr_o         = err_s;
  assign commit_o          = commit_r;
  assign trace_enable_o    = active_r.ctrl[0];
  assign cause_filter_o    = active_r.ctrl[1];
  assign tvec_filter_o     = active_r.ctrl[2];
  assign tval_filter_o     = active_r.ctrl[3];
  assign priv_lvl_filter_o = active_r.ctrl[4];
  assign iaddr_filter_o    = active_r.ctrl[5];
  assign cause_mode_o      = active_r.ctrl[6];
  assign tvec_mode_o       = active_r.ctrl[7];
  assign tval_mode_o       = active_r.ctrl[8];
  assign priv_lvl_mode_o   = active_r.ctrl[9];
  assign iaddr_mode_o      = active_r.ctrl[10];
  assign upper_cause_o     = active_r.cause[0];
  assign lower_cause_o     = active_r.cause[1];
  assign match_cause_o     = active_r.cause[2];
  assign upper_tvec_o      = active_r.tvec[0];
  assign lower_tvec_o      = active_r.tvec[1];
  assign match_tvec_o      = active_r.tvec[2];
  assign upper_tval_o      = active_r.tval[0];
  assign lower_tval_o      = active_r.tval[1];
  assign match_tval_o      = active_r.tval[2];
  assign upper_priv_lvl_o  = active_r.priv[0];
  assign lower_priv_lvl_o  = active_r.priv[1];
  assign match_priv_lvl_o  = active_r.priv[2];
  assign upper_iaddr_o     = active_r.iaddr[0];
  assign lower_iaddr_o     = active_r.iaddr[1];
  assign match_iaddr_o     = active_r.iaddr[2];

endmodule

// File: tb/tb_trdb_filter_regs.sv
// Bench for trdb_filter_regs: directed vector table, random APB traffic against a
// word-level register model, and an asynchronous reset during a pending commit.
module tb_trdb_filter_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready, pslverr, commit;
  logic        trace_enable_o, cause_filter_o, tvec_filter_o, tval_filter_o, priv_lvl_filter_o, iaddr_filter_o;
  logic        cause_mode_o, tvec_mode_o, tval_mode_o, priv_lvl_mode_o, iaddr_mode_o;
  logic [4:0]  upper_cause_o, lower_cause_o, match_cause_o;
  logic [29:0] upper_tvec_o, lower_tvec_o, match_tvec_o;
  logic [31:0] upper_tval_o, lower_tval_o, match_tval_o;
  logic [1:0]  upper_priv_lvl_o, lower_priv_lvl_o, match_priv_lvl_o;
  logic [31:0] upper_iaddr_o, lower_iaddr_o, match_iaddr_o;

  int total = 0;
  int bad   = 0;

  // Word-level model: index = byte offset / 4, values as software reads them back.
  logic [31:0] shadow_m [0:15];
  logic [31:0] act_m    [0:15];
  bit          pend_m;

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    bit          err;
  } vec_t;
  vec_t tbl [0:24];

  trdb_filter_regs dut (
    .clk_i(clk), .rst_ni(rst_n), .paddr_i(paddr), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .pwdata_i(pwdata), .prdata_o(prdata), .pready_o(pready), .pslverr_o(pslverr),
    .trace_enable_o(trace_enable_o), .cause_filter_o(cause_filter_o), .tvec_filter_o(tvec_filter_o),
    .tval_filter_o(tval_filter_o), .priv_lvl_filter_o(priv_lvl_filter_o), .iaddr_filter_o(iaddr_filter_o),
    .cause_mode_o(cause_mode_o), .tvec_mode_o(tvec_mode_o), .tval_mode_o(tval_mode_o),
    .priv_lvl_mode_o(priv_lvl_mode_o), .iaddr_mode_o(iaddr_mode_o),
    .upper_cause_o(upper_cause_o), .lower_cause_o(lower_cause_o), .match_cause_o(match_cause_o),
    .upper_tvec_o(upper_tvec_o), .lower_tvec_o(lower_tvec_o), .match_tvec_o(match_tvec_o),
    .upper_tval_o(upper_tval_o), .lower_tval_o(lower_tval_o), .match_tval_o(match_tval_o),
    .upper_priv_lvl_o(upper_priv_lvl_o), .lower_priv_lvl_o(lower_priv_lvl_o), .match_priv_lvl_o(match_priv_lvl_o),
    .upper_iaddr_o(upper_iaddr_o), .lower_iaddr_o(lower_iaddr_o), .match_iaddr_o(match_iaddr_o),
    .commit_o(commit)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mask(input int w);
    if (w == 0)       return 32'h0000_07FF;
    else if (w <= 3)  return 32'h0000_001F;
    else if (w <= 6)  return 32'hFFFF_FFFC;
    else if (w <= 9)  return 32'hFFFF_FFFF;
    else if (w <= 12) return 32'h0000_0003;
    else              return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      shadow_m[i] = 32'd0;
      act_m[i]    = 32'd0;
    end
    pend_m = 1'b0;
  endtask

  task automatic check_outs(input string name);
    logic [319:0] got, exp;
    logic [31:0]  c;
    c = act_m[0];
    got = {trace_enable_o, cause_filter_o, tvec_filter_o, tval_filter_o, priv_lvl_filter_o, iaddr_filter_o,
           cause_mode_o, tvec_mode_o, tval_mode_o, priv_lvl_mode_o, iaddr_mode_o,
           upper_cause_o, lower_cause_o, match_cause_o, upper_tvec_o, lower_tvec_o, match_tvec_o,
           upper_tval_o, lower_tval_o, match_tval_o, upper_priv_lvl_o, lower_priv_lvl_o, match_priv_lvl_o,
           upper_iaddr_o, lower_iaddr_o, match_iaddr_o};
    exp = 320'd0;
    for (int b = 0; b < 11; b++) exp = {exp[318:0], c[b]};
    for (int w = 1; w < 16; w++) begin
      if (w <= 3)       exp = {exp[314:0], act_m[w][4:0]};
      else if (w <= 6)  exp = {exp[289:0], act_m[w][31:2]};
      else if (w <= 9)  exp = {exp[287:0], act_m[w]};
      else if (w <= 12) exp = {exp[317:0], act_m[w][1:0]};
      else              exp = {exp[287:0], act_m[w]};
    end
    chk(name, got, exp);
  endtask

  task automatic apb(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output bit err);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(negedge clk);
    chk("prdata_setup", 320'(prdata), 320'd0);
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rdata = prdata;
    err   = pslverr;
    chk("pready", 320'(pready), 320'd1);
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  // One APB access plus model update; expectations from the table or from the model.
  task automatic do_op(input bit wr, input logic [7:0] addr, input logic [31:0] wdata,
                       input bit use_tbl, input logic [31:0] t_rd, input bit t_err);
    logic [31:0] rdata, m_rd;
    bit          err, m_err, do_commit;
    int          w;
    w = int'(addr[7:2]);
    m_err = (w > 16) || (wr && w == 16);
    m_rd  = (w < 16) ? shadow_m[w] : ((w == 16) ? {31'd0, pend_m} : 32'd0);
    apb(wr, addr, wdata, rdata, err);
    chk("pslverr", 320'(err), 320'(use_tbl ? t_err : m_err));
    if (!wr) chk("rdata", 320'(rdata), 320'(use_tbl ? t_rd : m_rd));
    do_commit = 1'b0;
    if (wr && !m_err) begin
      shadow_m[w] = wdata & mask(w);
      pend_m      = 1'b1;
      do_commit   = (w == 0) && wdata[31];
    end
    if (do_commit) begin
      chk("commit_early", 320'(commit), 320'd0);
      check_outs("outs_before_commit");
      @(posedge clk); #1;
      for (int i = 0; i < 16; i++) act_m[i] = shadow_m[i];
      pend_m = 1'b0;
      chk("commit_pulse", 320'(commit), 320'd1);
      check_outs("outs_after_commit");
      @(posedge clk); #1;
      chk("commit_once", 320'(commit), 320'd0);
    end else begin
      chk("commit_idle", 320'(commit), 320'd0);
      check_outs("outs");
    end
  endtask

  initial begin
    logic [31:0] rd;
    bit          er;
    tbl[0]  = '{1'b0, 8'h40, 32'h0,         32'h0000_0000, 1'b0};
    tbl[1]  = '{1'b0, 8'h04, 32'h0,         32'h0000_0000, 1'b0};
    tbl[2]  = '{1'b1, 8'h34, 32'h8000_0000, 32'h0,         1'b0};
    tbl[3]  = '{1'b1, 8'h38, 32'h0000_1000, 32'h0,         1'b0};
    tbl[4]  = '{1'b0, 8'h34, 32'h0,         32'h8000_0000, 1'b0};
    tbl[5]  = '{1'b0, 8'h38, 32'h0,         32'h0000_1000, 1'b0};
    tbl[6]  = '{1'b0, 8'h40, 32'h0,         32'h0000_0001, 1'b0};
    tbl[7]  = '{1'b1, 8'h44, 32'hDEAD_BEEF, 32'h0,         1'b1};
    tbl[8]  = '{1'b1, 8'h40, 32'h0000_0000, 32'h0,         1'b1};
    tbl[9]  = '{1'b0, 8'h40, 32'h0,         32'h0000_0001, 1'b0};
    tbl[10] = '{1'b0, 8'h44, 32'h0,         32'h0000_0000, 1'b1};
    tbl[11] = '{1'b1, 8'h00, 32'h8000_0221, 32'h0,         1'b0};
    tbl[12] = '{1'b0, 8'h40, 32'h0,         32'h0000_0000, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 32'h0,         32'h0000_0221, 1'b0};
    tbl[14] = '{1'b1, 8'h10, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[15] = '{1'b0, 8'h10, 32'h0,         32'hFFFF_FFFC, 1'b0};
    tbl[16] = '{1'b1, 8'h00, 32'h8000_0221, 32'h0,         1'b0};
    tbl[17] = '{1'b1, 8'h05, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[18] = '{1'b0, 8'h04, 32'h0,         32'h0000_001F, 1'b0};
    tbl[19] = '{1'b1, 8'h2B, 32'hFFFF_FFFF, 32'h0,         1'b0};
    tbl[20] = '{1'b0, 8'h28, 32'h0,         32'h0000_0003, 1'b0};
    tbl[21] = '{1'b0, 8'h30, 32'h0,         32'h0000_0000, 1'b0};
    tbl[22] = '{1'b1, 8'h00, 32'h0000_07FF, 32'h0,         1'b0};
    tbl[23] = '{1'b0, 8'h00, 32'h0,         32'h0000_07FF, 1'b0};
    tbl[24] = '{1'b0, 8'h40, 32'h0,         32'h0000_0001, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outs("outs_in_reset");
    chk("pready_in_reset", 320'(pready), 320'd1);
    chk("pslverr_in_reset", 320'(pslverr), 320'd0);
    chk("prdata_in_reset", 320'(prdata), 320'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check_outs("outs_after_reset");

    for (int i = 0; i < 25; i++)
      do_op(tbl[i].wr, tbl[i].addr, tbl[i].wdata, 1'b1, tbl[i].rd, tbl[i].err);

    // Active set still holds the second commit; the CTRL write of 0x7FF is only shadowed.
    chk("trace_enable", 320'(trace_enable_o), 320'd1);
    chk("iaddr_filter", 320'(iaddr_filter_o), 320'd1);
    chk("cause_filter", 320'(cause_filter_o), 320'd0);
    chk("upper_iaddr", 320'(upper_iaddr_o), 320'h8000_0000);
    chk("lower_iaddr", 320'(lower_iaddr_o), 320'h0000_1000);
    chk("upper_tvec", 320'(upper_tvec_o), 320'h3FFF_FFFF);
    chk("upper_cause_uncommitted", 320'(upper_cause_o), 320'd0);

    for (int n = 0; n < 400; n++) begin
      bit          wr;
      int          w;
      logic [31:0] d;
      logic [7:0]  a;
      wr = ($urandom_range(0, 1) == 1);
      w  = $urandom_range(0, 18);
      d  = $urandom;
      if (w == 0) d[31] = ($urandom_range(0, 3) == 0);
      a  = {w[5:0], 2'($urandom_range(0, 3))};
      do_op(wr, a, d, 1'b0, 32'd0, 1'b0);
    end

    // Reset asserted in the cycle the commit is pending must abort it.
    do_op(1'b1, 8'h1C, 32'h0000_1234, 1'b0, 32'd0, 1'b0);
    apb(1'b1, 8'h00, 32'h8000_0003, rd, er);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outs("outs_reset_mid_commit");
    chk("commit_reset_mid_commit", 320'(commit), 320'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("commit_aborted", 320'(commit), 320'd0);
    check_outs("outs_after_abort");
    for (int w = 0; w <= 16; w++)
      do_op(1'b0, 8'(w * 4), 32'd0, 1'b0, 32'd0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
